regfile_exec_seq: RTL and testbench

//  Multi-cycle execute sequencer placed directly downstream of regfile. It drives readnum,

---
 rtl/regfile_exec_seq_pkg.sv | 40 ++++
 rtl/regfile_exec_seq_shifter.sv | 23 ++
 rtl/regfile_exec_seq.sv | 158 +++++++++++++++
 tb/tb_regfile_exec_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_exec_seq_pkg.sv
// Shared opcode, shift, state and flag definitions for the execute sequencer.
package regfile_exec_seq_pkg;

  localparam int W_DEF  = 16;
  localparam int RW_DEF = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_AND = 2'b10,
    OP_MVN = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
  } flags_t;

  // Two's-complement overflow: addend signs agree but the sum sign differs.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/regfile_exec_seq_shifter.sv
// Single-bit shifter applied to operand B before the ALU.
module shifter16
  import regfile_exec_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] din,
  input  logic [1:0]   shift,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    case (shift_t'(shift))
      SH_NONE: dout = din;
      SH_LSL1: dout = {din[W-2:0], 1'b0};
      SH_LSR1: dout = {1'b0, din[W-1:1]};
      SH_ASR1: dout = {din[W-1], din[W-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/regfile_exec_seq.sv
// Multi-cycle execute sequencer: reads Rn/Rm from the regfile, runs the ALU, writes Rd back.
module regfile_exec_seq
  import regfile_exec_seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [1:0]    shift,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] rm,
  input  logic [RW-1:0] rd,
  input  logic [W-1:0]  rf_rdata,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic [W-1:0]  wb_data,
  output logic [2:0]    status,
  output logic          busy,
  output logic          done
);

  state_t        state;
  op_t           op_q;
  shift_t        sh_q;
  logic [RW-1:0] rm_q;
  logic [RW-1:0] rd_q;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  c_q;
  logic [W-1:0]  b_sh;
  logic [W-1:0]  b_neg;
  logic [W-1:0]  alu_res;
  logic          alu_v;
  flags_t        alu_flags;

  // The readnum register itself holds the latched rn, so no separate rn copy is kept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      sh_q     <= SH_NONE;
      rm_q     <= '0;
      rd_q     <= '0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      write <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op_t'(op);
            sh_q <= shift_t'(shift);
            rm_q <= rm;
            rd_q <= rd;
            busy <= 1'b1;
            if (op_t'(op) == OP_MVN) begin
              state   <= S_RDB;
              readnum <= rm;
            end else begin
              state   <= S_RDA;
              readnum <= rn;
            end
          end
        end
        S_RDA: begin
          state   <= S_RDB;
          readnum <= rm_q;
        end
        S_RDB: begin
          state   <= S_EXEC;
          readnum <= '0;
        end
        S_EXEC: begin
          state    <= S_WB;
          writenum <= rd_q;
          write    <= (op_q != OP_CMP);
          done     <= 1'b1;
        end
        S_WB: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          readnum <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_q <= '0;
    end else if (state == S_RDA) begin
      a_q <= rf_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      b_q <= '0;
    end else if (state == S_RDB) begin
      b_q <= rf_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_q    <= '0;
      status <= '0;
    end else if (state == S_EXEC) begin
      c_q    <= alu_res;
      status <= alu_flags;
    end
  end

  shifter16 #(.W(W)) u_shifter (
    .din   (b_q),
    .shift (sh_q),
    .dout  (b_sh)
  );

  // CMP is A plus the two's complement of Bsh so the same overflow rule covers both ops.
  always_comb begin
    b_neg   = ~b_sh + W'(1);
    alu_res = '0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = a_q + b_sh;
        alu_v   = add_ovf(a_q[W-1], b_sh[W-1], alu_res[W-1]);
      end
      OP_CMP: begin
        alu_res = a_q + b_neg;
        alu_v   = add_ovf(a_q[W-1], b_neg[W-1], alu_res[W-1]);
      end
      OP_AND:  alu_res = a_q & b_sh;
      OP_MVN:  alu_res = ~b_sh;
      default: alu_res = '0;
    endcase
    alu_flags.n = alu_res[W-1];
    alu_flags.v = alu_v;
    alu_flags.z = (alu_res == '0);
  end

  assign wb_data = c_q;

endmodule

// File: tb/tb_regfile_exec_seq.sv
// Directed bench for regfile_exec_seq with a behavioural 8x16 regfile attached.
module tb_regfile_exec_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [1:0]  shift;
  logic [2:0]  rn, rm, rd;
  logic [15:0] rf_rdata;
  logic [2:0]  readnum, writenum;
  logic        write;
  logic [15:0] wb_data;
  logic [2:0]  status;
  logic        busy, done;

  logic [15:0] rf [8];
  logic        clr, pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_exec_seq #(.W(16), .RW(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .shift    (shift),
    .rn       (rn),
    .rm       (rm),
    .rd       (rd),
    .rf_rdata (rf_rdata),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .wb_data  (wb_data),
    .status   (status),
    .busy     (busy),
    .done     (done)
  );

  assign rf_rdata = rf[readnum];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (write) begin
      rf[writenum] <= wb_data;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Launch one instruction, scramble the inputs after the start edge, optionally pulse
  // start again while busy, then check the WB cycle and the commit edge.
  task automatic run(input string tag, input logic [1:0] o, input logic [1:0] s,
                     input logic [2:0] n, input logic [2:0] m, input logic [2:0] d,
                     input int pulse_cyc, input int exp_lat, input logic exp_wr,
                     input logic [15:0] exp_wb, input logic [2:0] exp_st);
    int   cyc;
    logic early_wr;
    op = o; shift = s; rn = n; rm = m; rd = d; start = 1'b1;
    tick();
    start = 1'b0; op = ~o; shift = ~s; rn = ~n; rm = ~m; rd = ~d;
    cyc = 1;
    early_wr = 1'b0;
    check({tag, "_readnum1"}, 32'(readnum), (o == 2'b11) ? 32'(m) : 32'(n));
    while (!done && cyc < 12) begin
      if (write) early_wr = 1'b1;
      start = (cyc == pulse_cyc);
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_early_write"}, 32'(early_wr), 32'd0);
    check({tag, "_write"}, 32'(write), 32'(exp_wr));
    check({tag, "_writenum"}, 32'(writenum), 32'(d));
    check({tag, "_wb_data"}, 32'(wb_data), 32'(exp_wb));
    check({tag, "_status"}, 32'(status), 32'(exp_st));
    check({tag, "_busy_wb"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_write_after"}, 32'(write), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = '0; shift = '0; rn = '0; rm = '0; rd = '0;
    clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    tick();
    tick();
    clr = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_readnum", 32'(readnum), 32'd0);
    check("rst_writenum", 32'(writenum), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    reset_n = 1'b1;
    tick();

    preload(3'd1, 16'd7);
    preload(3'd2, 16'd3);

    // Reset asserted for two clocks while the ADD sits in EXEC.
    op = 2'b00; shift = 2'b01; rn = 3'd1; rm = 3'd2; rd = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_write", 32'(write), 32'd0);
    check("abort_status", 32'(status), 32'd0);
    reset_n = 1'b1;
    repeat (6) tick();
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_r3", 32'(rf[3]), 32'd0);

    // 7 + (3<<1) = 13
    run("add", 2'b00, 2'b01, 3'd1, 3'd2, 3'd3, 0, 4, 1'b1, 16'h000D, 3'b000);
    check("add_r3", 32'(rf[3]), 32'h000D);

    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    run("ovf", 2'b00, 2'b00, 3'd1, 3'd2, 3'd4, 0, 4, 1'b1, 16'h8000, 3'b110);
    check("ovf_r4", 32'(rf[4]), 32'h8000);

    preload(3'd5, 16'd9);
    preload(3'd6, 16'd9);
    run("cmp", 2'b01, 2'b00, 3'd5, 3'd6, 3'd2, 0, 4, 1'b0, 16'h0000, 3'b001);
    check("cmp_r2", 32'(rf[2]), 32'h0001);
    check("cmp_r5", 32'(rf[5]), 32'd9);

    // ASR of 8002 gives C001; MVN yields 3FFE.
    preload(3'd0, 16'h8002);
    run("mvn", 2'b11, 2'b11, 3'd0, 3'd0, 3'd7, 0, 3, 1'b1, 16'h3FFE, 3'b000);
    check("mvn_r7", 32'(rf[7]), 32'h3FFE);

    // R1 = R3+R3 = 0x1A (stray start pulsed mid-op), then R2 = R1 + (R1<<1) = 0x4E.
    run("b2b1", 2'b00, 2'b00, 3'd3, 3'd3, 3'd1, 2, 4, 1'b1, 16'h001A, 3'b000);
    run("b2b2", 2'b00, 2'b01, 3'd1, 3'd1, 3'd2, 0, 4, 1'b1, 16'h004E, 3'b000);
    repeat (6) tick();
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_r1", 32'(rf[1]), 32'h001A);
    check("b2b_r2", 32'(rf[2]), 32'h004E);
    check("b2b_r5", 32'(rf[5]), 32'd9);
    check("b2b_r6", 32'(rf[6]), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
